// File: rtl/spram_arbiter.sv
// Clears a single-port RAM after reset, then round-robin shares it between two requesters.
// Latency: ack one cycle after grant, read data combinational from ram_q; backpressure: req held until ack, loser waits.
module spram_arbiter #(
    parameter int                    ADDR_WIDTH  = 15,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    parameter bit                    INIT_ENABLE = 1'b1
) (
    input  logic                  clock_a,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_enable,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic [1:0]            outstanding;
    logic                  last_grant;
    logic [1:0]            eligible;
    logic                  grant_vld;
    logic                  grant_sel;

    // A requester whose access is in flight is masked so its still-high req is not granted twice.
    assign eligible = {r1_req, r0_req} & ~outstanding;

    always_comb begin
        grant_vld = (state == RUN) && (eligible != 2'b00);
        grant_sel = 1'b0;
        if (eligible == 2'b11) begin
            grant_sel = ~last_grant;
        end else if (eligible == 2'b10) begin
            grant_sel = 1'b1;
        end
    end

    assign r0_rdata = ram_q;
    assign r1_rdata = ram_q;

    always_ff @(posedge clock_a) begin
        if (reset) begin
            state       <= INIT_ENABLE ? INIT : RUN;
            sweep_cnt   <= '0;
            outstanding <= 2'b00;
            last_grant  <= 1'b1;
            init_done   <= 1'b0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            ram_enable  <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            r0_ack <= outstanding[0];
            r1_ack <= outstanding[1];
            if (state == INIT) begin
                outstanding <= 2'b00;
                ram_enable  <= 1'b1;
                ram_wren    <= 1'b1;
                ram_address <= sweep_cnt;
                ram_data    <= INIT_VALUE;
                sweep_cnt   <= sweep_cnt + ADDR_WIDTH'(1);
                // init_done follows one cycle later, once the last address has been driven.
                if (sweep_cnt == '1) begin
                    state <= RUN;
                end
            end else begin
                init_done <= 1'b1;
                if (grant_vld) begin
                    ram_enable  <= 1'b1;
                    ram_wren    <= grant_sel ? r1_we    : r0_we;
                    ram_address <= grant_sel ? r1_addr  : r0_addr;
                    ram_data    <= grant_sel ? r1_wdata : r0_wdata;
                    outstanding <= grant_sel ? 2'b10 : 2'b01;
                    last_grant  <= grant_sel;
                end else begin
                    ram_enable  <= 1'b0;
                    ram_wren    <= 1'b0;
                    outstanding <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a 16-word RAM model preloaded with 8'hFF.
module tb_spram_arbiter;

    typedef struct packed {
        logic       rd;
        logic [7:0] d;
    } exp_t;

    logic       clock_a = 1'b0;
    logic       reset   = 1'b1;
    logic       init_done;
    logic       r0_req = 1'b0, r0_we = 1'b0, r0_ack;
    logic [3:0] r0_addr = '0;
    logic [7:0] r0_wdata = '0, r0_rdata;
    logic       r1_req = 1'b0, r1_we = 1'b0, r1_ack;
    logic [3:0] r1_addr = '0;
    logic [7:0] r1_wdata = '0, r1_rdata;
    logic [3:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_enable, ram_wren;
    logic [7:0] ram_q = '0;

    logic [7:0]  mem [16];
    logic [15:0] written = '0;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   acc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    spram_arbiter #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .INIT_VALUE (8'h00),
        .INIT_ENABLE(1'b1)
    ) dut (
        .clock_a    (clock_a),
        .reset      (reset),
        .init_done  (init_done),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r0_ack     (r0_ack),
        .r0_rdata   (r0_rdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r1_ack     (r1_ack),
        .r1_rdata   (r1_rdata),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_enable (ram_enable),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clock_a = ~clock_a;

    // Unwritten words read back as the 8'hFF preload.
    always @(posedge clock_a) begin
        if (ram_enable) begin
            if (ram_wren) begin
                mem[ram_address]     <= ram_data;
                written[ram_address] <= 1'b1;
            end else begin
                ram_q <= written[ram_address] ? mem[ram_address] : 8'hFF;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_a) begin
        if (ram_enable && init_done) acc++;
        if (r0_ack) begin
            if (q0.size() == 0) begin
                chk("r0 spurious ack", 32'(r0_ack), 0);
            end else begin
                e0 = q0.pop_front();
                if (e0.rd) chk("r0 rdata", 32'(r0_rdata), 32'(e0.d));
            end
        end
        if (r1_ack) begin
            chk("ack overlap", 32'(r0_ack), 0);
            if (q1.size() == 0) begin
                chk("r1 spurious ack", 32'(r1_ack), 0);
            end else begin
                e1 = q1.pop_front();
                if (e1.rd) chk("r1 rdata", 32'(r1_rdata), 32'(e1.d));
            end
        end
    end

    task automatic set_req(input int n, input logic we, input logic [3:0] a,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
        exp_t e;
        e.rd = ~we;
        e.d  = exp_rd;
        if (n == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = wd;
            q0.push_back(e);
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = wd;
            q1.push_back(e);
        end
    endtask

    task automatic drop(input int n);
        if (n == 0) r0_req = 1'b0;
        else        r1_req = 1'b0;
    endtask

    // Returns how many falling edges it took to see the ack; the request is released right there.
    task automatic wait_ack(input int n, output int c);
        bit seen = 1'b0;
        c = 0;
        for (int i = 1; i <= 50 && !seen; i++) begin
            @(negedge clock_a);
            if ((n == 0) ? r0_ack : r1_ack) begin
                seen = 1'b1;
                c = i;
            end
        end
        if (!seen) chk("ack timeout", 32'((n == 0) ? r0_ack : r1_ack), 1);
        drop(n);
    endtask

    task automatic check_zero(input string name);
        chk(name, 32'({ram_enable, ram_wren, r0_ack, r1_ack, init_done, ram_address, ram_data}), 0);
    endtask

    task automatic check_sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock_a);
            chk(name, 32'({ram_enable, ram_wren, init_done, ram_address, ram_data}),
                32'({1'b1, 1'b1, 1'b0, 4'(i), 8'h00}));
        end
    endtask

    initial begin
        int c, a0, issued, n0, n1, who, prev, idx;
        logic [3:0] t4_a [3];
        logic [7:0] t4_d [3];
        t4_a = '{4'd3, 4'd5, 4'd7};
        t4_d = '{8'h11, 8'hA5, 8'h22};

        // 1: reset state, clear sweep with r0 read pending, then the first grant
        repeat (3) @(negedge clock_a);
        check_zero("reset outputs");
        set_req(0, 1'b0, 4'd2, 8'h00, 8'h00);
        reset = 1'b0;
        check_sweep("t1 sweep");
        wait_ack(0, c);
        chk("t1 first grant latency", c, 2);
        chk("t1 init_done", 32'(init_done), 1);

        // 2: write then read back through r0, exactly two RAM accesses
        @(negedge clock_a);
        a0 = acc;
        set_req(0, 1'b1, 4'd5, 8'hA5, 8'h00);
        wait_ack(0, c);
        chk("t2 write latency", c, 2);
        @(negedge clock_a);
        set_req(0, 1'b0, 4'd5, 8'h00, 8'hA5);
        wait_ack(0, c);
        chk("t2 read latency", c, 2);
        chk("t2 accesses", acc - a0, 2);

        // 3: ties; r1 setup writes leave the pointer on r1 so r0 wins the first tie
        @(negedge clock_a);
        set_req(1, 1'b1, 4'd3, 8'h11, 8'h00);
        wait_ack(1, c);
        chk("t3 setup latency", c, 2);
        @(negedge clock_a);
        set_req(1, 1'b1, 4'd7, 8'h22, 8'h00);
        wait_ack(1, c);
        @(negedge clock_a);
        set_req(0, 1'b0, 4'd3, 8'h00, 8'h11);
        set_req(1, 1'b0, 4'd7, 8'h00, 8'h22);
        wait_ack(0, c);
        chk("t3 tie r0 first", c, 2);
        wait_ack(1, c);
        chk("t3 r1 next cycle", c, 1);
        // A lone r0 access moves the pointer to r0, so the next tie goes to r1.
        @(negedge clock_a);
        set_req(0, 1'b0, 4'd5, 8'h00, 8'hA5);
        wait_ack(0, c);
        @(negedge clock_a);
        set_req(0, 1'b0, 4'd7, 8'h00, 8'h22);
        set_req(1, 1'b0, 4'd3, 8'h00, 8'h11);
        wait_ack(1, c);
        chk("t3 tie r1 first", c, 2);
        wait_ack(0, c);
        chk("t3 r0 next cycle", c, 1);

        // 4: both requesters saturate the port for 20 grants
        @(negedge clock_a);
        set_req(0, 1'b0, t4_a[0], 8'h00, t4_d[0]);
        set_req(1, 1'b0, t4_a[1], 8'h00, t4_d[1]);
        issued = 2; n0 = 0; n1 = 0; prev = -1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clock_a);
            if (i < 20) chk("t4 enable", 32'(ram_enable), 1);
            if (r0_ack || r1_ack) begin
                who = r1_ack ? 1 : 0;
                if (prev >= 0) chk("t4 alternate", who, 1 - prev);
                prev = who;
                if (who == 0) n0++; else n1++;
                if (issued < 20) begin
                    idx = issued % 3;
                    set_req(who, 1'b0, t4_a[idx[1:0]], 8'h00, t4_d[idx[1:0]]);
                    issued++;
                end else begin
                    drop(who);
                end
            end
        end
        chk("t4 r0 acks", n0, 10);
        chk("t4 r1 acks", n1, 10);

        // 6: req still high on the ack edge must not produce a second access
        @(negedge clock_a);
        a0 = acc;
        set_req(0, 1'b0, 4'd3, 8'h00, 8'h11);
        wait_ack(0, c);
        chk("t6 latency", c, 2);
        chk("t6 no regrant in ack cycle", 32'(ram_enable), 0);
        repeat (3) begin
            @(negedge clock_a);
            chk("t6 idle", 32'(ram_enable), 0);
        end
        chk("t6 accesses", acc - a0, 1);

        // 5: reset lands while an r1 write is in flight
        @(negedge clock_a);
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 4'd9; r1_wdata = 8'h77;
        @(negedge clock_a);
        chk("t5 grant", 32'({ram_enable, ram_wren, ram_address}), 32'({1'b1, 1'b1, 4'd9}));
        reset  = 1'b1;
        r1_req = 1'b0;
        @(negedge clock_a);
        check_zero("t5 reset outputs");
        @(negedge clock_a);
        reset = 1'b0;
        check_sweep("t5 sweep restart");
        set_req(0, 1'b0, 4'd9, 8'h00, 8'h00);
        wait_ack(0, c);
        chk("t5 grant after sweep", c, 2);
        chk("t5 init_done", 32'(init_done), 1);

        repeat (3) @(negedge clock_a);
        chk("r0 queue drained", q0.size(), 0);
        chk("r1 queue drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
